// File: rtl/clap_timer_pkg.sv
// rtl/clap_timer_pkg.sv - shared channel state and mode encodings for clap_timer
package clap_timer_pkg;

    typedef enum logic {
        PAUSE = 1'b0,
        COUNT = 1'b1
    } ch_state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/clap_timer_ch.sv
// rtl/clap_timer_ch.sv - one clap_timer channel: PAUSE/COUNT FSM, saturating counter, done/busy
module clap_timer_ch
    import clap_timer_pkg::*;
#(
    parameter int WIDTH    = 17,
    parameter int MAXCOUNT = 66080
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tick_i,
    input  logic             go_i,
    input  logic             stop_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAXCOUNT);
    localparam logic [WIDTH-1:0] LAST_C = WIDTH'(MAXCOUNT - 1);

    ch_state_e        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= PAUSE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Priority inside COUNT: go (restart) > stop (hold and pause) > tick.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            PAUSE: begin
                if (go_i) begin
                    state_d = COUNT;
                    count_d = '0;
                end
            end
            COUNT: begin
                if (go_i) begin
                    count_d = '0;
                end else if (stop_i) begin
                    state_d = PAUSE;
                end else if (tick_i) begin
                    if (count_q == MAX_C) begin
                        // Only reachable in periodic mode: the tick after terminal restarts at 0.
                        count_d = '0;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                        if (count_q == LAST_C) begin
                            done_d = 1'b1;
                            if (mode_i == MODE_ONESHOT) begin
                                state_d = PAUSE;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = PAUSE;
            end
        endcase
    end

    assign count_o = count_q;
    assign busy_o  = (state_q == COUNT);
    assign done_o  = done_q;

endmodule

// File: rtl/clap_timer.sv
// rtl/clap_timer.sv - multi-channel clap interval timer; CLAP_TIMER_SNAPSHOT_EN adds capture-to-snap registers
module clap_timer
    import clap_timer_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int WIDTH    = 17,
    parameter int MAXCOUNT = 66080,
    parameter int PRESCALE = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       go,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       mode,
    input  logic                    capture,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH*WIDTH-1:0] snap
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             pre_last;
    logic             tick;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // With PRESCALE=1 pre stays at 0, so pre_last is constant and tick reduces to en.
    always_comb begin
        pre_last = (pre_q == PRE_LAST);
        tick     = en && pre_last;
        pre_d    = pre_q;
        if (en) begin
            pre_d = pre_last ? '0 : pre_q + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clap_timer_ch #(
            .WIDTH    (WIDTH),
            .MAXCOUNT (MAXCOUNT)
        ) u_ch (
            .clk     (clk),
            .resetn  (resetn),
            .tick_i  (tick),
            .go_i    (go[i]),
            .stop_i  (stop[i]),
            .mode_i  (mode[i]),
            .count_o (count[i*WIDTH +: WIDTH]),
            .busy_o  (busy[i]),
            .done_o  (done[i])
        );
    end

`ifdef CLAP_TIMER_SNAPSHOT_EN
    logic [NUM_CH*WIDTH-1:0] snap_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            snap_q <= '0;
        end else if (capture) begin
            snap_q <= count;
        end
    end

    assign snap = snap_q;
`else
    logic unused_capture;

    assign unused_capture = capture;
    assign snap           = '0;
`endif

endmodule

// File: doc/clap_timer.md
# clap_timer

Multi-channel, parametrised interval timer for the clap-detection path. It generalises the single 17-bit clap counter with configurable width, terminal count, channel count and tick prescaling. It adds a per-channel one-shot or periodic mode, an explicit stop and a done pulse. Sits between the input front-end (which raises `go` on a detected clap) and the scoring/display logic that reads `count` and `done`.

## Interface
Parameters:
- `NUM_CH`, 2: number of independent counter channels (≥1)
- `WIDTH`, 17: counter width per channel
- `MAXCOUNT`, 66080: terminal count; 1 ≤ MAXCOUNT ≤ 2^WIDTH−1
- `PRESCALE`, 1: enabled clk cycles per count tick (≥1)

Ports:
- `clk`  in  1  system clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `en`  in  1  global count enable; gates the prescaler
- `go`  in  NUM_CH  per-channel start/restart, level sampled each edge
- `stop`  in  NUM_CH  per-channel abort to PAUSE
- `mode`  in  NUM_CH  per channel: 0 = one-shot, 1 = periodic
- `capture`  in  1  snapshot strobe (see Configuration)
- `count`  out  NUM_CH*WIDTH  channel i at [i*WIDTH +: WIDTH]
- `busy`  out  NUM_CH  1 while channel is in COUNT
- `done`  out  NUM_CH  one-cycle pulse on reaching MAXCOUNT
- `snap`  out  NUM_CH*WIDTH  captured counts

## Operation
- Shared prescaler `pre`, range 0..PRESCALE−1:
  - While `en`=1: increments; wraps to 0 when it reaches PRESCALE−1, and `tick`=1 on that cycle.
  - While `en`=0: holds, `tick`=0.
  - PRESCALE=1 gives `tick`=`en`.
- Per-channel FSM, states PAUSE and COUNT:
  - PAUSE: count holds. `go`=1 → COUNT, count←0.
  - COUNT, `go`=1: restart, count←0, stay COUNT. `go` beats `stop` and `tick`.
  - COUNT, `stop`=1 (no `go`): → PAUSE, count holds current value.
  - COUNT, `tick`=1, count<MAXCOUNT: count←count+1.
  - On the increment that makes count = MAXCOUNT, `done` pulses for one cycle, coincident with count first showing MAXCOUNT.
    - One-shot: → PAUSE, count holds MAXCOUNT.
    - Periodic: stay COUNT; on the next `tick`, count←0 and counting continues.
- `mode` is sampled at every terminal event; a change mid-count takes effect at the next terminal event.
- Channels are fully independent except for the shared `tick`.
- Count never exceeds MAXCOUNT and never wraps at 2^WIDTH.

## Timing
- All outputs are registered; no combinational input→output path.
- Reset values: all `count`=0, `snap`=0, `busy`=0, `done`=0, every FSM in PAUSE, `pre`=0.
- `resetn` asserted mid-count clears the channel immediately (asynchronously). After deassertion the channel waits in PAUSE for `go`.
- `go` sampled at edge N → `busy`=1 and count=0 visible after edge N.
- With `en` held high, the first increment occurs PRESCALE ticks' worth of cycles later, counted from the current prescaler phase.
- One-shot with `en` held high and PRESCALE=1: `done` appears MAXCOUNT cycles after `busy` rises.

## Configuration
- `CLAP_TIMER_SNAPSHOT_EN` defined:
  - `capture`=1 at an edge latches every channel's `count` (its pre-edge value) into `snap` at that edge.
  - `snap` holds until the next capture.
- Not defined:
  - `capture` is ignored and `snap` is tied to 0.
  - No snapshot registers are synthesised.
  - Port list is unchanged.

## Structure
- Package `clap_timer_pkg`:
  - state enum `{PAUSE, COUNT}`
  - mode constants `MODE_ONESHOT`=0, `MODE_PERIODIC`=1
- Sub-module `clap_timer_ch`:
  - one channel's FSM, counter and done/busy registers
  - parameters WIDTH and MAXCOUNT
  - instantiated NUM_CH times via generate
- The top level holds the prescaler and the snapshot registers.

## Test plan
- Reset, then `en`=1, PRESCALE=1, MAXCOUNT=5, one-shot, `go[0]` pulsed for one cycle → count0 steps 0,1,2,3,4,5. `done[0]` is high only on the cycle count0=5. `busy[0]` then falls and count0 holds 5.
- Periodic mode, MAXCOUNT=3 → sequence 0,1,2,3,0,1,2,3…; `done` pulses once per period, 4 cycles apart.
- PRESCALE=4, `en` toggled low for 2 cycles mid-run → increments every 4 enabled cycles; the prescaler holds during `en`=0.
- `go[1]`=1 and `stop[1]`=1 on the same cycle while count1=7 → count1=0 and `busy[1]` stays 1. `stop[1]` alone at count1=2 → PAUSE with count1 held at 2.
- `resetn` pulled low while count0=3 → count0, `busy`, `done` and `snap` go to 0 immediately. The channel stays idle after release until `go`.
- With `CLAP_TIMER_SNAPSHOT_EN` defined: `capture` pulsed at count0=2, count1=4 → `snap` = {4,2} held constant while counting continues. Without the macro, `snap` stays 0.
